// File: rtl/bit_unstuff.sv
// rtl/bit_unstuff.sv - USB receive bit unstuffer: drops the stuffed 0 after MAX_ONES 1s, flags violations
module bit_unstuff #(
  parameter int MAX_ONES = 6
) (
  input  logic clk,
  input  logic rst_b,
  input  logic bstr_in,
  input  logic bstr_in_ready,
  input  logic in_done,
  output logic bstr_out,
  output logic bstr_out_ready,
  output logic out_done,
  output logic stuff_err
);

  localparam int CW = $clog2(MAX_ONES + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_ONES);

  typedef enum logic [1:0] {IDLE, RUN, STUFF, ERR} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_ones_cnt;
  logic            r_bstr_out;
  logic            r_bstr_out_ready;
  logic            r_out_done;
  logic            r_stuff_err;
  logic [CW-1:0]   w_cnt_inc;

  assign w_cnt_inc = r_ones_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state          <= IDLE;
      r_ones_cnt       <= '0;
      r_bstr_out       <= 1'b0;
      r_bstr_out_ready <= 1'b0;
      r_out_done       <= 1'b0;
      r_stuff_err      <= 1'b0;
    end else begin
      r_bstr_out_ready <= 1'b0;
      r_out_done       <= 1'b0;
      // The error flag stays visible through the out_done cycle, then clears.
      if (r_out_done) begin
        r_stuff_err <= 1'b0;
      end
      if (in_done) begin
        r_out_done <= 1'b1;
        r_ones_cnt <= '0;
        r_state    <= IDLE;
      end else if (bstr_in_ready) begin
        case (r_state)
          IDLE, RUN: begin
            r_bstr_out       <= bstr_in;
            r_bstr_out_ready <= 1'b1;
            if (bstr_in) begin
              r_ones_cnt <= w_cnt_inc;
              r_state    <= (w_cnt_inc == MAX_CNT) ? STUFF : RUN;
            end else begin
              r_ones_cnt <= '0;
              r_state    <= RUN;
            end
          end
          STUFF: begin
            if (bstr_in) begin
              r_stuff_err <= 1'b1;
              r_state     <= ERR;
            end else begin
              r_ones_cnt <= '0;
              r_state    <= RUN;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bstr_out       = r_bstr_out;
  assign bstr_out_ready = r_bstr_out_ready;
  assign out_done       = r_out_done;
  assign stuff_err      = r_stuff_err;

endmodule

// File: tb/tb_bit_unstuff.sv
// tb/tb_bit_unstuff.sv - self-checking bench for bit_unstuff against a packet-level reference model
module tb_bit_unstuff;

  localparam int MAX_ONES = 6;

  logic clk;
  logic rst_b;
  logic bstr_in;
  logic bstr_in_ready;
  logic in_done;
  logic bstr_out;
  logic bstr_out_ready;
  logic out_done;
  logic stuff_err;

  int vectors;
  int miscompares;

  bit_unstuff #(.MAX_ONES(MAX_ONES)) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .bstr_in        (bstr_in),
    .bstr_in_ready  (bstr_in_ready),
    .in_done        (in_done),
    .bstr_out       (bstr_out),
    .bstr_out_ready (bstr_out_ready),
    .out_done       (out_done),
    .stuff_err      (stuff_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: number of 1s seen since the last 0 or packet start, plus a
  // "packet poisoned" flag; expected registered outputs after each clock edge.
  int   m_ones;
  bit   m_drop;
  logic m_out, m_rdy, m_done, m_err;
  logic got[$];

  function automatic void model_reset();
    m_ones = 0; m_drop = 0;
    m_out = 0; m_rdy = 0; m_done = 0; m_err = 0;
  endfunction

  function automatic void model_step(input logic b, input logic r, input logic d);
    logic prev_done;
    prev_done = m_done;
    m_rdy = 0;
    m_done = 0;
    if (prev_done) m_err = 0;
    if (d) begin
      m_done = 1; m_ones = 0; m_drop = 0;
    end else if (r && !m_drop) begin
      if (m_ones == MAX_ONES) begin
        if (b) begin m_err = 1; m_drop = 1; end
        else m_ones = 0;
      end else begin
        m_out = b; m_rdy = 1;
        m_ones = b ? m_ones + 1 : 0;
      end
    end
  endfunction

  function automatic logic [3:0] exp_vec();
    return {m_out, m_rdy, m_done, m_err};
  endfunction

  function automatic string got_str();
    string s;
    s = "";
    foreach (got[i]) s = {s, got[i] ? "1" : "0"};
    return s;
  endfunction

  task automatic cycle(input logic b, input logic r, input logic d);
    bstr_in = b; bstr_in_ready = r; in_done = d;
    @(posedge clk); #1;
    model_step(b, r, d);
    bstr_in = 0; bstr_in_ready = 0; in_done = 0;
    if (bstr_out_ready) got.push_back(bstr_out);
  endtask

  task automatic apply_char(input byte c);
    case (c)
      "1":     cycle(1'b1, 1'b1, 1'b0);
      "0":     cycle(1'b0, 1'b1, 1'b0);
      "D":     cycle(1'b0, 1'b0, 1'b1);
      default: cycle(1'b0, 1'b0, 1'b0);
    endcase
  endtask

  task automatic test_reset();
    vectors++;
    if ({bstr_out, bstr_out_ready, out_done, stuff_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_initial got=%b want=0000", {bstr_out, bstr_out_ready, out_done, stuff_err});
    end
    rst_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      vectors++;
      if ({bstr_out, bstr_out_ready, out_done, stuff_err} !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_prebits got=%b want=%b", {bstr_out, bstr_out_ready, out_done, stuff_err}, exp_vec());
      end
    end
    #2 rst_b = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({bstr_out, bstr_out_ready, out_done, stuff_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_async got=%b want=0000", {bstr_out, bstr_out_ready, out_done, stuff_err});
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    cycle(1'b1, 1'b1, 1'b0);
    vectors++;
    if ({bstr_out, bstr_out_ready, out_done, stuff_err} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_first_bit got=%b want=1100", {bstr_out, bstr_out_ready, out_done, stuff_err});
    end
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_no_stuff();
    string s;
    s = "10110010D.";
    got.delete();
    for (int i = 0; i < s.len(); i++) begin
      apply_char(s[i]);
      vectors++;
      if ({bstr_out, bstr_out_ready, out_done, stuff_err} !== exp_vec()) begin
        miscompares++;
        $display("FAIL no_stuff[%0d] got=%b want=%b", i, {bstr_out, bstr_out_ready, out_done, stuff_err}, exp_vec());
      end
    end
    vectors++;
    if (got_str() != "10110010") begin
      miscompares++;
      $display("FAIL no_stuff_stream got=%s want=10110010", got_str());
    end
  endtask

  task automatic test_stuffed_zero();
    string s;
    s = "11111101D.";
    got.delete();
    for (int i = 0; i < s.len(); i++) begin
      apply_char(s[i]);
      vectors++;
      if ({bstr_out, bstr_out_ready, out_done, stuff_err} !== exp_vec()) begin
        miscompares++;
        $display("FAIL stuffed_zero[%0d] got=%b want=%b", i, {bstr_out, bstr_out_ready, out_done, stuff_err}, exp_vec());
      end
    end
    vectors++;
    if (got_str() != "1111111") begin
      miscompares++;
      $display("FAIL stuffed_zero_stream got=%s want=1111111", got_str());
    end
  endtask

  task automatic test_violation();
    string s;
    s = "111111101D.";
    got.delete();
    for (int i = 0; i < s.len(); i++) begin
      apply_char(s[i]);
      vectors++;
      if ({bstr_out, bstr_out_ready, out_done, stuff_err} !== exp_vec()) begin
        miscompares++;
        $display("FAIL violation[%0d] got=%b want=%b", i, {bstr_out, bstr_out_ready, out_done, stuff_err}, exp_vec());
      end
      if (s[i] == "D") begin
        vectors++;
        if ({out_done, stuff_err} !== 2'b11) begin
          miscompares++;
          $display("FAIL violation_eop got=%b want=11", {out_done, stuff_err});
        end
      end
    end
    vectors++;
    if (got_str() != "111111" || stuff_err !== 1'b0) begin
      miscompares++;
      $display("FAIL violation_stream got=%s err=%b want=111111 err=0", got_str(), stuff_err);
    end
  endtask

  task automatic test_gaps();
    string s;
    s = "1.1..1.1.1...1..0.0.D.";
    got.delete();
    for (int i = 0; i < s.len(); i++) begin
      apply_char(s[i]);
      vectors++;
      if ({bstr_out, bstr_out_ready, out_done, stuff_err} !== exp_vec()) begin
        miscompares++;
        $display("FAIL gaps[%0d] got=%b want=%b", i, {bstr_out, bstr_out_ready, out_done, stuff_err}, exp_vec());
      end
    end
    vectors++;
    if (got_str() != "1111110") begin
      miscompares++;
      $display("FAIL gaps_stream got=%s want=1111110", got_str());
    end
  endtask

  task automatic test_run_at_eop();
    string s;
    s = "111111D.0.D.";
    got.delete();
    for (int i = 0; i < s.len(); i++) begin
      apply_char(s[i]);
      vectors++;
      if ({bstr_out, bstr_out_ready, out_done, stuff_err} !== exp_vec()) begin
        miscompares++;
        $display("FAIL run_at_eop[%0d] got=%b want=%b", i, {bstr_out, bstr_out_ready, out_done, stuff_err}, exp_vec());
      end
    end
    vectors++;
    if (got_str() != "1111110") begin
      miscompares++;
      $display("FAIL run_at_eop_stream got=%s want=1111110", got_str());
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int k = 0; k <= len; k++) begin
        logic b, r, d;
        d = (k == len);
        r = d ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
        b = ($urandom_range(0, 7) != 0);
        cycle(b, r, d);
        vectors++;
        if ({bstr_out, bstr_out_ready, out_done, stuff_err} !== exp_vec()) begin
          miscompares++;
          $display("FAIL random[p%0d k%0d] got=%b want=%b", p, k, {bstr_out, bstr_out_ready, out_done, stuff_err}, exp_vec());
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_b = 1'b0;
    bstr_in = 0; bstr_in_ready = 0; in_done = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_no_stuff();
    test_stuffed_zero();
    test_violation();
    test_gaps();
    test_run_at_eop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
